// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/interrupt controller: ExcCodes,
// CP0 Status/Cause bit positions, FSM encoding and EPC helper.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_IM_LO  = 10;
    localparam int STATUS_IM_HI  = 14;
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_EXC_LO  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_RETURN = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] victim_pc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchroniser for the asynchronous hardware interrupt lines.
module int_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller feeding CP0: arbitrates MEM-stage exceptions,
// synchronised interrupts and ERET, and drives flush/redirect to the front end.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [4:0]  hw_int,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    output logic        cp0_exl,
    output logic        cp0_bd,
    output logic [4:0]  cp0_int,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_epc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  drain_q;
    logic        exl_q;
    logic        arb;
    logic        int_ok;
    logic        take_exc, take_int, take_eret;
    logic        unused_status;

    int_sync #(.WIDTH(5)) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (hw_int),
        .sync_out (cp0_int)
    );

    assign int_ok = mem_valid & status_in[STATUS_IE] & ~exl_q
                  & (|(cp0_int & status_in[STATUS_IM_HI:STATUS_IM_LO]));
    assign unused_status = ^{status_in[31:STATUS_IM_HI+1], status_in[STATUS_IM_LO-1:STATUS_IE+1]};

    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        arb            = 1'b0;
        take_exc       = 1'b0;
        take_int       = 1'b0;
        take_eret      = 1'b0;
        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_ENTER, ST_RETURN: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                state_d        = ST_DRAIN;
            end
            ST_DRAIN: begin
                flush = 1'b1;
                // The edge closing the last drain cycle may already accept work.
                if (drain_q == 3'd0) begin
                    state_d = ST_IDLE;
                    arb     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (arb) begin
            if (mem_valid && exc_req)      take_exc  = 1'b1;
            else if (int_ok)               take_int  = 1'b1;
            else if (mem_valid && eret)    take_eret = 1'b1;
        end
        if (take_exc || take_int) state_d = ST_ENTER;
        else if (take_eret)       state_d = ST_RETURN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= 3'd0;
            exl_q       <= 1'b0;
            cp0_bd      <= 1'b0;
            cp0_exccode <= 5'd0;
            cp0_epc     <= 32'd0;
            redirect_pc <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ENTER || state_q == ST_RETURN)
                drain_q <= DRAIN_LAST;
            else if (state_q == ST_DRAIN && drain_q != 3'd0)
                drain_q <= drain_q - 3'd1;
            if (take_exc || take_int) begin
                exl_q       <= 1'b1;
                cp0_bd      <= mem_bd;
                cp0_exccode <= take_exc ? exc_code : EXC_INT;
                cp0_epc     <= victim_pc(mem_pc, mem_bd);
                redirect_pc <= EXC_VECTOR;
            end else if (take_eret) begin
                exl_q       <= 1'b0;
                redirect_pc <= epc_in;
            end
        end
    end

    assign cp0_exl = exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: entry, return, interrupts, drain and async reset.
module tb_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        eret;
    logic [4:0]  hw_int;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic        cp0_exl;
    logic        cp0_bd;
    logic [4:0]  cp0_int;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_bd         (mem_bd),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .eret           (eret),
        .hw_int         (hw_int),
        .status_in      (status_in),
        .epc_in         (epc_in),
        .cp0_exl        (cp0_exl),
        .cp0_bd         (cp0_bd),
        .cp0_int        (cp0_int),
        .cp0_exccode    (cp0_exccode),
        .cp0_epc        (cp0_epc),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0;
        exc_req   = 1'b0;
        eret      = 1'b0;
        mem_bd    = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        mem_valid = 1'b0; mem_pc = 32'd0; mem_bd = 1'b0; exc_req = 1'b0;
        exc_code = 5'd0; eret = 1'b0; hw_int = 5'd0;
        status_in = 32'd0; epc_in = 32'd0;
        #12;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_exl", {31'd0, cp0_exl}, 32'd0);
        chk("rst_epc", cp0_epc, 32'd0);
        chk("rst_int", {27'd0, cp0_int}, 32'd0);
        rst = 1'b1;
        tick(); tick();

        // Overflow at 0x400, not in delay slot
        mem_valid = 1; mem_pc = 32'h400; exc_req = 1; exc_code = 5'd12;
        tick();
        idle_inputs();
        chk("ov_code", {27'd0, cp0_exccode}, 32'd12);
        chk("ov_epc", cp0_epc, 32'h400);
        chk("ov_bd", {31'd0, cp0_bd}, 32'd0);
        chk("ov_exl", {31'd0, cp0_exl}, 32'd1);
        chk("ov_rv", {31'd0, redirect_valid}, 32'd1);
        chk("ov_rpc", redirect_pc, 32'h180);
        chk("ov_flush0", {31'd0, flush}, 32'd1);
        tick();
        chk("ov_rv_drop", {31'd0, redirect_valid}, 32'd0);
        chk("ov_flush1", {31'd0, flush}, 32'd1);
        tick();
        chk("ov_flush2", {31'd0, flush}, 32'd1);
        tick();
        chk("ov_flush_end", {31'd0, flush}, 32'd0);
        chk("ov_exl_held", {31'd0, cp0_exl}, 32'd1);

        // ERET returns to EPC
        mem_valid = 1; eret = 1; epc_in = 32'h2000;
        tick();
        idle_inputs();
        chk("eret_exl", {31'd0, cp0_exl}, 32'd0);
        chk("eret_rv", {31'd0, redirect_valid}, 32'd1);
        chk("eret_rpc", redirect_pc, 32'h2000);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        tick(); tick(); tick();
        chk("eret_idle", {31'd0, flush}, 32'd0);

        // Syscall in a delay slot
        mem_valid = 1; mem_pc = 32'h1000; mem_bd = 1; exc_req = 1; exc_code = 5'd8;
        tick();
        idle_inputs();
        chk("sys_epc", cp0_epc, 32'hFFC);
        chk("sys_bd", {31'd0, cp0_bd}, 32'd1);
        chk("sys_code", {27'd0, cp0_exccode}, 32'd8);
        tick(); tick(); tick();
        mem_valid = 1; eret = 1; epc_in = 32'h1004;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        chk("sys_ret_exl", {31'd0, cp0_exl}, 32'd0);

        // Exception and ERET together: exception wins
        mem_valid = 1; mem_pc = 32'h500; exc_req = 1; exc_code = 5'd9; eret = 1; epc_in = 32'h3000;
        tick();
        idle_inputs();
        chk("both_code", {27'd0, cp0_exccode}, 32'd9);
        chk("both_exl", {31'd0, cp0_exl}, 32'd1);
        chk("both_rpc", redirect_pc, 32'h180);
        tick(); tick(); tick();
        chk("both_exl_hold", {31'd0, cp0_exl}, 32'd1);

        // Interrupt blocked while EXL is set
        status_in = 32'h0000_1001; hw_int = 5'b00100; mem_valid = 1; mem_pc = 32'h600;
        tick();
        chk("sync_1edge", {27'd0, cp0_int}, 32'd0);
        tick();
        chk("sync_2edge", {27'd0, cp0_int}, 32'd4);
        tick();
        chk("int_exl_block", {31'd0, redirect_valid}, 32'd0);
        chk("int_exl_noflush", {31'd0, flush}, 32'd0);
        eret = 1; epc_in = 32'h3000;
        tick();
        chk("int_ret_exl", {31'd0, cp0_exl}, 32'd0);
        idle_inputs(); status_in = 32'h0000_1000;
        tick(); tick(); tick();

        // Interrupt blocked with IE=0, then taken with IE=1
        mem_valid = 1;
        tick();
        chk("int_ie0_block", {31'd0, redirect_valid}, 32'd0);
        status_in = 32'h0000_1001;
        tick();
        chk("int_ie1_rv", {31'd0, redirect_valid}, 32'd1);
        chk("int_ie1_code", {27'd0, cp0_exccode}, 32'd0);
        chk("int_ie1_epc", cp0_epc, 32'h600);
        idle_inputs(); hw_int = 5'd0;
        tick(); tick(); tick();
        mem_valid = 1; eret = 1; epc_in = 32'h600;
        tick();
        idle_inputs();
        tick(); tick(); tick();

        // Fresh interrupt: taken on the third edge
        hw_int = 5'b00100; mem_valid = 1; mem_pc = 32'h700;
        tick();
        chk("int3_e1", {31'd0, redirect_valid}, 32'd0);
        tick();
        chk("int3_e2", {31'd0, redirect_valid}, 32'd0);
        tick();
        chk("int3_e3_rv", {31'd0, redirect_valid}, 32'd1);
        chk("int3_e3_epc", cp0_epc, 32'h700);
        idle_inputs(); hw_int = 5'd0;

        // Request pulsed during the first drain cycle is dropped
        tick();
        mem_valid = 1; exc_req = 1; exc_code = 5'd10; mem_pc = 32'h800;
        tick();
        idle_inputs();
        chk("drain_ign_rv", {31'd0, redirect_valid}, 32'd0);
        chk("drain_ign_code", {27'd0, cp0_exccode}, 32'd0);
        tick();
        chk("drain_ign_idle", {31'd0, flush | redirect_valid}, 32'd0);
        tick();
        chk("drain_ign_rv2", {31'd0, redirect_valid}, 32'd0);

        // Request held through drain is accepted again (nested, EPC overwritten)
        mem_valid = 1; exc_req = 1; exc_code = 5'd5; mem_pc = 32'h900;
        tick();
        chk("hold_first", cp0_epc, 32'h900);
        exc_code = 5'd4; mem_pc = 32'hA00;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (redirect_valid) found = 1'b1;
        end
        chk("hold_accepted", {31'd0, found}, 32'd1);
        chk("hold_code", {27'd0, cp0_exccode}, 32'd4);
        chk("hold_epc", cp0_epc, 32'hA00);
        idle_inputs();

        // Asynchronous reset in the middle of drain
        tick();
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("arst_exl", {31'd0, cp0_exl}, 32'd0);
        chk("arst_rpc", redirect_pc, 32'd0);
        #3 rst = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, flush}, 32'd0);
        mem_valid = 1; exc_req = 1; exc_code = 5'd10; mem_pc = 32'hB00;
        tick();
        idle_inputs();
        chk("post_rst_take", {31'd0, redirect_valid}, 32'd1);
        chk("post_rst_code", {27'd0, cp0_exccode}, 32'd10);
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt controller sitting directly upstream of the CP0 register block. It samples the pipeline's MEM-stage exception requests and ERET, synchronises the external interrupt lines, and arbitrates between them. It produces the EXL/BD/ExcCode/IP/EPC values CP0 latches, plus flush and PC-redirect commands for the pipeline front end. It consumes CP0's Status and EPC outputs to gate interrupts and service ERET.

## Interface
- EXC_VECTOR, 32'h0000_0180: redirect target on exception entry
- DRAIN_CYCLES, 2: cycles flush stays asserted after entry/return (1..7)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  32  PC of MEM-stage instruction
- mem_bd  in  1  MEM instruction is in a branch delay slot
- exc_req  in  1  MEM instruction raised a synchronous exception
- exc_code  in  5  its ExcCode (4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
- eret  in  1  MEM instruction is ERET
- hw_int  in  5  raw asynchronous interrupt lines
- status_in  in  32  CP0 Status (IE = bit 0, IM = bits 14:10)
- epc_in  in  32  CP0 EPC
- cp0_exl  out  1  EXL level driven to CP0
- cp0_bd  out  1  BD value for CP0 Cause
- cp0_int  out  5  synchronised pending lines for CP0 Cause IP
- cp0_exccode  out  5  ExcCode for CP0 Cause
- cp0_epc  out  32  EPC value for CP0
- flush  out  1  kill IF..MEM contents
- redirect_valid  out  1  one-cycle PC load strobe
- redirect_pc  out  32  PC to load

## Operation
- hw_int passes through a 2-flop synchroniser; cp0_int = synchroniser output, always updated.
- Interrupt eligible when mem_valid & status_in[0] & ~exl_q & |(cp0_int & status_in[14:10]).
- Priority in IDLE: (1) mem_valid & exc_req; (2) eligible interrupt (ExcCode 0); (3) mem_valid & eret. Lower-priority events in the same cycle are dropped.
- Accepted exception/interrupt: latch cp0_exccode, cp0_bd = mem_bd, cp0_epc = mem_bd ? mem_pc-4 : mem_pc (32-bit wraparound subtraction); set exl_q; go ENTER.
- Accepted ERET: clear exl_q; redirect_pc = epc_in; go RETURN. ERET with exl_q=0 is still honoured.
- States:
  - IDLE: arbitration as above.
  - ENTER: 1 cycle; redirect_valid=1, redirect_pc=EXC_VECTOR, flush=1 → DRAIN.
  - RETURN: 1 cycle; redirect_valid=1, flush=1 → DRAIN.
  - DRAIN: flush=1 for DRAIN_CYCLES cycles, all requests ignored → IDLE.
- cp0_exl = exl_q, a level held between entry and ERET. A sync exception while exl_q=1 is still taken (nested); EPC/BD are overwritten.
- Reset values: state IDLE, exl_q 0, cp0_bd 0, cp0_exccode 0, cp0_epc 0, cp0_int 0, synchroniser 0, flush 0, redirect_valid 0, redirect_pc 0.

## Timing
- Request sampled on edge N: cp0_* updated and ENTER/RETURN outputs visible after edge N (cycle N+1). CP0 captures them on edge N+1.
- flush is high for 1 + DRAIN_CYCLES consecutive cycles. The next request can be accepted on the edge closing the last DRAIN cycle.
- hw_int assertion → cp0_int: 2 edges. The interrupt can be taken on the 3rd edge at the earliest.
- Reset asserted mid-ENTER/DRAIN: all outputs drop to reset values immediately (asynchronously). No partial redirect is held.

## Structure
- Shared package: ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), Status/Cause bit positions, FSM state encoding.
- One sub-module: int_sync (5-bit two-flop synchroniser with async active-low reset).

## Test plan
- Ov at mem_pc=0x400, mem_bd=0 → cycle+1: exccode=12, epc=0x400, exl=1, redirect_valid=1, redirect_pc=0x180, flush high for 3 cycles.
- Syscall with mem_bd=1, mem_pc=0x1000 → epc=0xFFC, bd=1.
- hw_int[2]=1, status_in=0x0000_1001 (IE=1, IM bit 12) → taken on 3rd edge with exccode=0. Same stimulus with IE=0, or with exl=1, → no entry.
- exc_req and eret in the same cycle → exception taken, exl stays 1. Separately, eret with epc_in=0x2000 → exl=0, redirect_pc=0x2000.
- Request arriving during DRAIN → ignored, no second redirect. Request held into IDLE → accepted.
- rst pulled low during DRAIN → flush/redirect_valid/exl go 0 without waiting for a clock. After release, FSM is in IDLE.
